// File: rtl/gpio_switch_debounce.sv
// Per-bit two-flop synchroniser and stability-counter debouncer for board switches.
// Produces a registered clean level plus one-cycle rise/fall/change strobes.
module gpio_switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             SYSTEMCLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_stable,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             switch_changed
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("gpio_switch_debounce: DEBOUNCE_CYCLES must be 2 or more");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("gpio_switch_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync0_q, sync1_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  // A change is accepted on the edge after the counter has seen DEBOUNCE_CYCLES-1
  // consecutive deviations, so the level must differ for DEBOUNCE_CYCLES edges.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync1_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync1_q[i];
        rise_d[i]   = sync1_q[i];
        fall_d[i]   = ~sync1_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge SYSTEMCLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync0_q   <= switch_raw;
      sync1_q   <= sync0_q;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switch_stable  = stable_q;
  assign switch_rise    = rise_q;
  assign switch_fall    = fall_q;
  assign switch_changed = changed_q;

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Bench for gpio_switch_debounce: directed steps then random switch activity,
// checked every cycle against a sliding-window model of the acceptance rule.
module tb_gpio_switch_debounce;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw;
  logic [W-1:0] stable_o, rise_o, fall_o;
  logic         changed_o;

  int checks = 0;
  int errors = 0;

  gpio_switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .SYSTEMCLOCK   (clk),
    .RESET_N       (rst_n),
    .switch_raw    (raw),
    .switch_stable (stable_o),
    .switch_rise   (rise_o),
    .switch_fall   (fall_o),
    .switch_changed(changed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist holds the raw value sampled at each of the last D+2 edges
  // (newest at the back). An edge accepts a bit when the D synchronised samples
  // ending two edges back all differ from the current stable level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_rise, m_fall;
  int rise_cnt[W];
  int fall_cnt[W];
  int chg_cnt;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back('0);
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
  endtask

  task automatic model_edge();
    logic [W-1:0] acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back(raw);
      void'(hist.pop_front());
      acc = '1;
      for (int k = 0; k < D; k++) acc = acc & (hist[k] ^ m_stable);
      m_rise   = acc & ~m_stable;
      m_fall   = acc & m_stable;
      m_stable = m_stable ^ acc;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("stable", 32'(stable_o), 32'(m_stable));
    check("rise", 32'(rise_o), 32'(m_rise));
    check("fall", 32'(fall_o), 32'(m_fall));
    check("changed", 32'(changed_o), 32'(|(m_rise | m_fall)));
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    chg_cnt = 0;
  endtask

  // One clock: model follows the active edge, DUT is sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < W; i++) begin
      if (rise_o[i] === 1'b1) rise_cnt[i]++;
      if (fall_o[i] === 1'b1) fall_cnt[i]++;
    end
    if (changed_o === 1'b1) chg_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive_for(input logic [W-1:0] v, input int n);
    raw = v;
    ticks(n);
  endtask

  // Clearing must be visible before any clock edge arrives.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_stable", 32'(stable_o), 32'h0);
    check("rst_rise", 32'(rise_o), 32'h0);
    check("rst_fall", 32'(fall_o), 32'h0);
    check("rst_changed", 32'(changed_o), 32'h0);
    ticks(cycles);
    rst_n = 1'b1;
  endtask

  int n;
  int hold[W];

  initial begin
    rst_n = 1'b1;
    raw   = '0;
    model_reset();
    clear_counts();
    #2;

    // Reset hold, then quiet running with switches at 0.
    do_reset(5);
    ticks(50);
    check("quiet_changes", 32'(chg_cnt), 32'd0);

    // Clean step on bit 0: accepted on edge D+2 after the sampling edge.
    clear_counts();
    raw = 4'h1;
    n = 0;
    do begin tick(); n++; end while (stable_o !== 4'h1 && n < 40);
    check("step_latency", 32'(n), 32'(D + 2));
    ticks(5);
    check("step_rise_pulses", 32'(rise_cnt[0]), 32'd1);
    check("step_changed_pulses", 32'(chg_cnt), 32'd1);
    check("step_fall_pulses", 32'(fall_cnt[0]), 32'd0);

    // Return bit 0 low, then bounce it before holding high.
    drive_for(4'h0, 15);
    clear_counts();
    drive_for(4'h1, 3);
    drive_for(4'h0, 2);
    drive_for(4'h1, 5);
    drive_for(4'h0, 1);
    raw = 4'h1;
    n = 0;
    do begin tick(); n++; end while (stable_o !== 4'h1 && n < 40);
    check("bounce_latency", 32'(n), 32'(D + 2));
    ticks(5);
    check("bounce_rise_pulses", 32'(rise_cnt[0]), 32'd1);
    check("bounce_fall_pulses", 32'(fall_cnt[0]), 32'd0);

    // Glitches on bit 2: one cycle short of acceptance, then exactly long enough.
    drive_for(4'h0, 15);
    clear_counts();
    drive_for(4'h4, D - 1);
    drive_for(4'h0, 20);
    check("glitch_short_changes", 32'(chg_cnt), 32'd0);
    check("glitch_short_stable", 32'(stable_o), 32'h0);
    drive_for(4'h4, D);
    raw = 4'h0;
    n = 0;
    do begin tick(); n++; end while (fall_o[2] !== 1'b1 && n < 40);
    check("glitch_fall_latency", 32'(n), 32'(D + 2));
    ticks(5);
    check("glitch_rise_pulses", 32'(rise_cnt[2]), 32'd1);
    check("glitch_fall_pulses", 32'(fall_cnt[2]), 32'd1);

    // Simultaneous multi-bit changes.
    clear_counts();
    drive_for(4'hA, D + 6);
    check("multi_a_changed", 32'(chg_cnt), 32'd1);
    check("multi_a_rise1", 32'(rise_cnt[1]), 32'd1);
    check("multi_a_rise3", 32'(rise_cnt[3]), 32'd1);
    clear_counts();
    drive_for(4'h5, D + 6);
    check("multi_5_changed", 32'(chg_cnt), 32'd1);
    check("multi_5_rise0", 32'(rise_cnt[0]), 32'd1);
    check("multi_5_fall3", 32'(fall_cnt[3]), 32'd1);

    // Reset in the middle of a count; switches held at F across it.
    drive_for(4'hF, 7);
    do_reset(1);
    n = 0;
    do begin tick(); n++; end while (stable_o !== 4'hF && n < 40);
    check("midrst_latency", 32'(n), 32'(D + 2));
    check("midrst_rise", 32'(rise_o), 32'hF);
    ticks(5);

    // Random per-bit hold times straddling the acceptance threshold.
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 2 * D);
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          raw[i]  = ~raw[i];
          hold[i] = $urandom_range(1, 2 * D);
        end
      end
      if (c == 600) do_reset($urandom_range(1, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_switch_debounce.md
Name: gpio_switch_debounce

Overview:
- Sits directly upstream of the top-level LED logic, between the raw board switches and the gpio_switch inputs of main.
- Synchronises each asynchronous switch bit into the SYSTEMCLOCK domain and filters contact bounce with a per-bit stability counter.
- Delivers a clean, registered switch vector plus one-cycle rise/fall/change strobes, so downstream logic never sees metastable or bouncing levels.

Parameters:
- WIDTH, 4, number of switch bits.
- DEBOUNCE_CYCLES, 100000, consecutive cycles a synchronised bit must differ from its stable value before the change is accepted. At 100 MHz this is 1 ms. Legal range is 2 or more; benches use 8.
- CNT_W, 17, per-bit counter width. It must satisfy 2^CNT_W >= DEBOUNCE_CYCLES, checked at elaboration with $error.

Ports:
- SYSTEMCLOCK  input  1  system clock, 100 MHz nominal, all state on rising edge
- RESET_N  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is expected to be synchronous upstream
- switch_raw  input  WIDTH  raw asynchronous board switches
- switch_stable  output  WIDTH  debounced switch levels
- switch_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change
- switch_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change
- switch_changed  output  1  one-cycle pulse when any bit is accepted in either direction (OR of rise and fall)

Behaviour:
- Reset: while RESET_N=0, the following are 0 for every bit: sync0, sync1, counters, switch_stable, switch_rise, switch_fall, switch_changed. Clearing is immediate and does not wait for a clock edge.
- Synchroniser: 2 flops per bit, sync0<=switch_raw and sync1<=sync0. No logic sits between them.
- Per-bit counter, evaluated every rising edge:
  - If sync1==switch_stable[i], cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1, then switch_stable[i]<=sync1 and cnt[i]<=0. In the same edge, switch_rise[i]<=sync1 and switch_fall[i]<=~sync1.
  - Else cnt[i]<=cnt[i]+1.
- Strobes: rise, fall and changed are registered and high for exactly one cycle. They are asserted in the same cycle that switch_stable takes its new value; otherwise they are 0.
- Latency: count the first edge that samples the new raw level into sync0 as edge 1. switch_stable updates on edge DEBOUNCE_CYCLES+2, and the strobe is visible in the cycle after that edge.
- Glitch rejection: a deviation held fewer than DEBOUNCE_CYCLES synchronised cycles returns the counter to 0. No output changes.
- Restart: if sync1 returns to stable for even one cycle, the count restarts from 0.
- Bit independence: bits are independent. Simultaneous accepted changes on several bits assert their individual strobes in the same cycle, and switch_changed is a single pulse.
- Counter range: the counter saturates logically because it resets at DEBOUNCE_CYCLES-1, so it never wraps.
- Mid-operation reset: reset during a count abandons it. After release, stable=0, so a switch held at 1 produces a rise pulse DEBOUNCE_CYCLES+2 edges after release. This is intentional: downstream logic sees a defined edge.
- Structure: no combinational path from switch_raw to any output.

Test Plan:
- Reset hold, D=8, switch_raw=4'h0, RESET_N low for 5 cycles then high -> all outputs 0 throughout; no strobes for 50 cycles.
- Clean step: switch_raw 4'h0->4'h1, held -> switch_stable=4'h1 exactly on edge 10 after the sampling edge; switch_rise=4'h1 and switch_changed=1 for exactly 1 cycle; fall stays 0.
- Bounce on bit 0: pulses of 3 cycles high, 2 low, 5 high, 1 low, then held high -> exactly one rise pulse, 10 edges after the final transition to held-high; no intermediate stable change.
- Glitch: 7-cycle pulse on bit 2 -> switch_stable stays 4'h0, no strobes. Repeat with an 8-cycle pulse -> one rise, then one fall 10 edges after the pulse falls.
- Multi-bit: 4'h0->4'hA in one cycle -> switch_rise=4'hA for 1 cycle; switch_changed is a single 1-cycle pulse. Then 4'hA->4'h5 -> rise=4'h5 and fall=4'hA in the same cycle.
- Mid-count reset: start 4'hF, pulse RESET_N low for 1 cycle at count 5, keep raw=4'hF -> outputs clear immediately; stable=4'hF with rise=4'hF 10 edges after reset release.
